// File: rtl/inv_sub_bytes_ctrl.sv
// rtl/inv_sub_bytes_ctrl.sv - multi-cycle AES inverse SubBytes over a 128-bit state, LANES bytes per cycle

module subBytes_inv (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    // Table entry for input value v sits at bits [8*(255-v) +: 8].
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    assign out_byte = INV_SBOX[{~in_byte, 3'b000} +: 8];
endmodule

module inv_sub_bytes_ctrl #(
    parameter int LANES = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [3:0] LAST_CNT = 4'(16 - LANES);
    localparam logic [3:0] STEP     = 4'(LANES);

    state_t         state;
    logic [3:0]     cnt;
    logic [127:0]   work;
    logic [127:0]   work_next;
    logic [3:0]     lane_idx [LANES];
    logic [7:0]     lane_out [LANES];

    // Byte k lives at bits [8*(15-k) +: 8]; 15-k is ~k in four bits.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign lane_idx[g] = cnt + 4'(g);
        subBytes_inv u_sbox (
            .in_byte  (work[{~lane_idx[g], 3'b000} +: 8]),
            .out_byte (lane_out[g])
        );
    end

    always_comb begin
        work_next = work;
        for (int g = 0; g < LANES; g++) begin
            work_next[{~lane_idx[g], 3'b000} +: 8] = lane_out[g];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
            work  <= 128'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work  <= state_in;
                        cnt   <= 4'd0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    work <= work_next;
                    if (cnt == LAST_CNT) begin
                        cnt   <= 4'd0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + STEP;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign state_out = work;
endmodule

// File: tb/tb_inv_sub_bytes_ctrl.sv
// tb/tb_inv_sub_bytes_ctrl.sv - directed bench for inv_sub_bytes_ctrl at LANES 1, 4 and 16

module tb_inv_sub_bytes_ctrl;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] state_in = '0;
    logic         out_ready = 1'b0;
    logic         iv1 = 1'b0, iv4 = 1'b0, iv16 = 1'b0;
    logic         ir1, ir4, ir16, ov1, ov4, ov16, bz1, bz4, bz16;
    logic [127:0] so1, so4, so16;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    inv_sub_bytes_ctrl #(.LANES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .state_in(state_in),
        .out_valid(ov1), .out_ready(out_ready), .state_out(so1), .busy(bz1));
    inv_sub_bytes_ctrl #(.LANES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .state_in(state_in),
        .out_valid(ov4), .out_ready(out_ready), .state_out(so4), .busy(bz4));
    inv_sub_bytes_ctrl #(.LANES(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .state_in(state_in),
        .out_valid(ov16), .out_ready(out_ready), .state_out(so16), .busy(bz16));

    int           sel = 1;
    logic         s_ir, s_ov, s_bz;
    logic [127:0] s_so;

    always_comb begin
        s_ir = ir1; s_ov = ov1; s_bz = bz1; s_so = so1;
        if (sel == 4) begin
            s_ir = ir4; s_ov = ov4; s_bz = bz4; s_so = so4;
        end else if (sel == 16) begin
            s_ir = ir16; s_ov = ov16; s_bz = bz16; s_so = so16;
        end
    end

    task automatic set_iv(input logic v);
        iv1 = (sel == 1) ? v : 1'b0;
        iv4 = (sel == 4) ? v : 1'b0;
        iv16 = (sel == 16) ? v : 1'b0;
    endtask

    // Called #1 after an edge with the selected DUT idle; returns edges from accept to out_valid.
    task automatic run_op(input logic [127:0] din, output logic acc, output int lat, output logic busy_ok);
        state_in = din;
        set_iv(1'b1);
        @(posedge clk); #1;
        set_iv(1'b0);
        acc = s_bz;
        busy_ok = 1'b1;
        lat = 0;
        while (!s_ov && lat < 40) begin
            if (!s_bz) busy_ok = 1'b0;
            state_in = {4{$urandom()}};
            @(posedge clk); #1;
            lat++;
        end
        if (!s_bz) busy_ok = 1'b0;
    endtask

    task automatic release_output();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] obs [3];
        #2;
        obs[0] = {ir1, ov1, bz1, |so1};
        obs[1] = {ir4, ov4, bz4, |so4};
        obs[2] = {ir16, ov16, bz16, |so16};
        for (int i = 0; i < 3; i++) begin
            total++;
            if (obs[i] !== 4'b1000) begin
                bad++;
                $display("FAIL reset_outputs dut%0d got ir/ov/bz/so_nz=%b want 1000", i, obs[i]);
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_lanes1_63();
        logic acc, bok; int lat;
        sel = 1;
        run_op({16{8'h63}}, acc, lat, bok);
        total++; if (!acc) begin bad++; $display("FAIL l1_accept got busy=%b want 1", acc); end
        total++; if (lat != 16) begin bad++; $display("FAIL l1_latency got %0d want 16", lat); end
        total++; if (s_so !== 128'd0) begin bad++; $display("FAIL l1_result got %h want 0", s_so); end
        total++; if (!bok) begin bad++; $display("FAIL l1_busy got busy dropped want busy held"); end
        release_output();
        total++; if (s_ir !== 1'b1 || s_bz !== 1'b0) begin
            bad++; $display("FAIL l1_return_idle got ir=%b bz=%b want 1 0", s_ir, s_bz);
        end
    endtask

    task automatic test_lanes1_mixed();
        logic acc, bok; int lat;
        logic [127:0] exp_v;
        exp_v = {8'h00, 8'h01, 8'h48, {13{8'hff}}};
        sel = 1;
        run_op({8'h63, 8'h7c, 8'h52, {13{8'h16}}}, acc, lat, bok);
        total++; if (s_so !== exp_v) begin bad++; $display("FAIL l1_mixed got %h want %h", s_so, exp_v); end
        release_output();
    endtask

    task automatic test_wide_lanes();
        logic acc, bok; int lat;
        sel = 4;
        run_op(128'd0, acc, lat, bok);
        total++; if (lat != 4) begin bad++; $display("FAIL l4_latency got %0d want 4", lat); end
        total++; if (s_so !== {16{8'h52}}) begin bad++; $display("FAIL l4_result got %h want all 52", s_so); end
        release_output();
        sel = 16;
        run_op(128'd0, acc, lat, bok);
        total++; if (lat != 1) begin bad++; $display("FAIL l16_latency got %0d want 1", lat); end
        total++; if (s_so !== {16{8'h52}}) begin bad++; $display("FAIL l16_result got %h want all 52", s_so); end
        release_output();
    endtask

    task automatic test_backpressure();
        logic acc, bok; int lat;
        logic stable;
        sel = 1;
        run_op({16{8'h16}}, acc, lat, bok);
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                state_in = {16{8'h63}};
                iv1 = 1'b1;
            end
            @(posedge clk); #1;
            if (s_so !== {16{8'hff}} || !s_ov) stable = 1'b0;
        end
        total++; if (!stable) begin bad++; $display("FAIL bp_hold got so=%h ov=%b want all ff and 1", s_so, s_ov); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++; if ({s_ir, s_ov, s_bz} !== 3'b100) begin
            bad++; $display("FAIL bp_handshake_edge got ir/ov/bz=%b want 100", {s_ir, s_ov, s_bz});
        end
        @(posedge clk); #1;
        iv1 = 1'b0;
        total++; if (s_bz !== 1'b1) begin bad++; $display("FAIL bp_next_accept got busy=%b want 1", s_bz); end
        lat = 0;
        while (!s_ov && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        total++; if (lat != 16 || s_so !== 128'd0) begin
            bad++; $display("FAIL bp_second_op got lat=%0d so=%h want 16 and 0", lat, s_so);
        end
        release_output();
    endtask

    task automatic test_reset_mid_run();
        logic acc, bok; int lat;
        sel = 1;
        state_in = {16{8'h55}};
        iv1 = 1'b1;
        @(posedge clk); #1;
        iv1 = 1'b0;
        repeat (7) begin @(posedge clk); end
        #1;
        rst_n = 1'b0;
        #1;
        total++; if ({ir1, ov1, bz1} !== 3'b100 || so1 !== 128'd0) begin
            bad++; $display("FAIL midrun_reset got ir/ov/bz=%b so=%h want 100 and 0", {ir1, ov1, bz1}, so1);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_op({16{8'h63}}, acc, lat, bok);
        total++; if (!acc || lat != 16 || s_so !== 128'd0) begin
            bad++; $display("FAIL midrun_recover got acc=%b lat=%0d so=%h want 1 16 0", acc, lat, s_so);
        end
        release_output();
    endtask

    task automatic test_back_to_back();
        logic [127:0] ins [3];
        logic [127:0] exps [3];
        int idx, res, cyc, last_acc;
        logic pre_ready;
        ins[0] = 128'd0;            exps[0] = {16{8'h52}};
        ins[1] = {16{8'h63}};       exps[1] = 128'd0;
        ins[2] = {4{32'h637c5216}}; exps[2] = {4{32'h000148ff}};
        sel = 4;
        out_ready = 1'b1;
        idx = 0; res = 0; cyc = 0; last_acc = -1;
        state_in = ins[0];
        iv4 = 1'b1;
        while (res < 3 && cyc < 200) begin
            pre_ready = ir4;
            @(posedge clk); #1;
            cyc++;
            if (pre_ready && iv4) begin
                if (last_acc >= 0) begin
                    total++;
                    if (cyc - last_acc != 6) begin
                        bad++; $display("FAIL b2b_spacing op%0d got %0d want 6", idx, cyc - last_acc);
                    end
                end
                last_acc = cyc;
                idx++;
                if (idx < 3) state_in = ins[idx];
                else iv4 = 1'b0;
            end
            if (ov4) begin
                total++;
                if (so4 !== exps[res]) begin
                    bad++; $display("FAIL b2b_result op%0d got %h want %h", res, so4, exps[res]);
                end
                res++;
            end
        end
        total++; if (res != 3) begin bad++; $display("FAIL b2b_timeout got %0d results want 3", res); end
        iv4 = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lanes1_63();
        test_lanes1_mixed();
        test_wide_lanes();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/inv_sub_bytes_ctrl.md
INV_SUB_BYTES_CTRL -- requirements
Module: inv_sub_bytes_ctrl

Interface
REQ-001 The block SHALL have parameter: LANES, 1, number of subBytes_inv instances used per cycle; legal values 1, 2, 4, 8, 16.
REQ-002 The block SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 The block SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port: in_valid  input  1  state_in presented for processing.
REQ-005 The block SHALL have port: in_ready  output  1  block can accept a new state.
REQ-006 The block SHALL have port: state_in  input  128  AES state; byte k = bits [127-8k -: 8], k=0..15.
REQ-007 The block SHALL have port: out_valid  output  1  state_out holds a completed result.
REQ-008 The block SHALL have port: out_ready  input  1  downstream accepts the result.
REQ-009 The block SHALL have port: state_out  output  128  inverse-SubBytes of the accepted state, same byte order.
REQ-010 The block SHALL have port: busy  output  1  high in RUN and DONE.

Function
REQ-011 The block SHALL instantiate exactly LANES subBytes_inv instances and compute every byte through them; no additional S-box tables.
REQ-012 The block SHALL implement FSM states IDLE, RUN and DONE; in_ready = (state == IDLE); out_valid = (state == DONE).
REQ-013 On a rising edge with state IDLE and in_valid high, the block SHALL load state_in into the internal 128-bit work register, clear byte counter cnt to 0 and enter RUN.
REQ-014 In RUN, on each edge, the block SHALL replace bytes cnt..cnt+LANES-1 of the work register with their subBytes_inv outputs, then increase cnt by LANES.
REQ-015 On the RUN edge that processes the final byte group (cnt == 16-LANES), the block SHALL enter DONE; cnt SHALL wrap to 0.
REQ-016 out_valid SHALL first be high exactly 16/LANES cycles after the accepting edge: LANES=1 gives 16, LANES=16 gives 1.
REQ-017 In DONE, state_out and out_valid SHALL hold stable until an edge with out_ready high; on that edge the block SHALL enter IDLE.
REQ-018 After an output handshake, in_ready SHALL be high the following cycle; the block SHALL NOT accept a new input on the output-handshake edge itself.
REQ-019 While busy, in_valid and state_in SHALL be ignored; state_in changes during RUN SHALL NOT affect the result.
REQ-020 state_out SHALL be driven directly from the work register at all times; its value SHALL only be meaningful while out_valid is high.
REQ-021 Bytes not yet processed in RUN SHALL retain their loaded value; each byte SHALL be transformed exactly once per operation.
REQ-022 out_ready high outside DONE SHALL have no effect.

Reset
REQ-023 On rst_n low, independent of clk, the block SHALL enter IDLE, clear cnt to 0 and clear the work register to 0.
REQ-024 While rst_n is low, outputs SHALL be: in_ready=1, out_valid=0, busy=0, state_out=0.
REQ-025 Reset asserted during RUN or DONE SHALL discard the operation with no result; the first edge after rst_n rises SHALL accept a new input if in_valid is high.

Verification
REQ-026 The bench SHALL cover, with LANES=1, state_in=all 0x63 and in_valid pulsed one cycle: out_valid rises 16 cycles after accept, state_out=all 0x00, busy=1 throughout.
REQ-027 The bench SHALL cover, with LANES=1, state_in = bytes 63,7c,52, then 13 bytes of 16: state_out = bytes 00,01,48, then 13 bytes of ff.
REQ-028 The bench SHALL cover, with LANES=4, state_in=all 0x00: out_valid after 4 cycles, state_out=all 0x52; repeat for LANES=16 and require 1 cycle.
REQ-029 The bench SHALL cover a backpressure case: out_ready held low 5 cycles in DONE, then a new state_in with in_valid high applied meanwhile; state_out stays constant and the new input is not taken until the cycle after the out_ready handshake.
REQ-030 The bench SHALL cover reset mid-RUN: rst_n low at cnt=7 gives immediate in_ready=1, out_valid=0, state_out=0; a following all-0x63 input completes normally with all 0x00.
REQ-031 The bench SHALL cover back-to-back operations: 3 consecutive states with out_ready tied high; each result is correct, and each operation occupies 16/LANES+2 cycles from accept to the next accept.
